// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared state type and default sizing for uart_tx_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_NUM_REQ = 4;
  localparam int UART_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : one-hot round-robin pick, search from last_grant+1 upward. Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    grant   = '0;
    w_sum   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    // One extra bit so the wrap subtraction works for non-power-of-two counts.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, last_grant} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter : N requesters share one UART TX; packet lock via UART_ARB_LOCK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = UART_NUM_REQ,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        idle
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic [DATA_W-1:0]  w_byte;
  logic               w_hs;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic w_last;
  // While a packet is open only the requester that opened it is eligible.
  assign w_elig = lock_q ? (req_valid & (NUM_REQ'(1) << last_grant_q)) : req_valid;
`else
  logic w_unused_last;
  assign w_elig        = req_valid;
  assign w_unused_last = ^req_last;
`endif

  rr_arbiter #(
    .NUM_REQ    (NUM_REQ)
  ) u_rr (
    .req        (w_elig),
    .last_grant (last_grant_q),
    .grant      (w_grant)
  );

  always_comb begin
    w_idx  = '0;
    w_byte = '0;
`ifdef UART_ARB_LOCK_EN
    w_last = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_idx  = ID_W'(i);
        w_byte = req_data[i*DATA_W +: DATA_W];
`ifdef UART_ARB_LOCK_EN
        w_last = req_last[i];
`endif
      end
    end
  end

  // rst_n gates the strobe so no handshake is signalled while flops are held.
  assign w_hs = rst_n && (state_q == IDLE) && !tx_busy && (|w_elig);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    req_ready    = '0;
    tx_start     = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d       = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_hs) begin
          req_ready    = w_grant;
          state_d      = ISSUE;
          last_grant_d = w_idx;
          grant_id_d   = w_idx;
          tx_data_d    = w_byte;
`ifdef UART_ARB_LOCK_EN
          lock_d       = !w_last;
`endif
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ-1);
      grant_id_q   <= '0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`endif

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign idle     = (state_q == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter (honours UART_ARB_LOCK_EN). Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int IDW      = $clog2(N);
  localparam int BUSY_LEN = 10;

  typedef struct { logic [W-1:0] d; logic l; } byte_t;
  typedef struct { int id; logic [W-1:0] d; int cyc; } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [IDW-1:0] grant_id;
  logic           idle;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, starts = 0, cyc = 0;
  byte_t rq [N][$];
  exp_t  expq[$];
  int    glog[$];
  logic [W-1:0] dlog[$];
  logic [N-1:0] gap_en = '1;
  bit rand_gap = 0, rand_busy = 0, force_busy = 0;
  int busy_cnt = 0;
  bit start_seen = 0;
  int lg = N-1, lid = 0;
  bit locked = 0;
  logic [W-1:0] cur = '0;
  bit have = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference rule: locked -> only the lock owner; else first valid after lg.
  function automatic int pick(input logic [N-1:0] v);
    if (locked) return v[IDW'(lid)] ? lid : -1;
    for (int k = 1; k <= N; k++) begin
      int c = (lg + k) % N;
      if (v[IDW'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic int first1(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[IDW'(i)]) return i;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
    return 1;
  endfunction

  always @(posedge clk) cyc++;

  // Requester driver: each requester presents the head of its byte queue.
  always @(posedge clk) begin
    #1;
    if (rand_gap) gap_en = N'($urandom);
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        req_valid = gap_en[IDW'(i)] ? (req_valid | (N'(1) << i)) : (req_valid & ~(N'(1) << i));
        req_data[i*W +: W] = rq[i][0].d;
        req_last = rq[i][0].l ? (req_last | (N'(1) << i)) : (req_last & ~(N'(1) << i));
      end else begin
        req_valid = req_valid & ~(N'(1) << i);
        req_last  = req_last & ~(N'(1) << i);
        req_data[i*W +: W] = '0;
      end
    end
  end

  // Transmitter model: busy rises the cycle after tx_start.
  assign tx_busy = force_busy || (busy_cnt != 0);
  always @(negedge clk) start_seen = tx_start;
  always @(posedge clk) begin
    #1;
    if (!rst_n) busy_cnt = 0;
    else if (start_seen) busy_cnt = rand_busy ? int'($urandom_range(10, 1)) : BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt--;
    start_seen = 0;
  end

  // Handshake observer: checks the grant and queues the expected transmission.
  always @(negedge clk) begin
    if (!rst_n) begin
      lg = N-1; locked = 0; lid = 0;
      expq.delete();
    end else begin
      logic [N-1:0] hs;
      int p, a;
      hs = req_ready & req_valid;
      p  = pick(req_valid);
      if (req_ready != '0) begin
        check("ready_while_busy", int'(tx_busy), 0);
        check("ready_outside_idle", int'(idle), 1);
        check("ready_winner", int'(req_ready), (p < 0) ? 0 : (1 << p));
      end
      if (hs != '0) begin
        a = first1(hs);
        if (p >= 0) begin
          exp_t e;
          e.id = p; e.d = rq[p][0].d; e.cyc = cyc;
          expq.push_back(e);
`ifdef UART_ARB_LOCK_EN
          locked = !rq[p][0].l;
          lid    = p;
`endif
          lg = p;
        end
        glog.push_back(a);
        if (rq[a].size() != 0) void'(rq[a].pop_front());
      end
    end
  end

  // Transmit monitor: every tx_start must match a queued handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 0;
    end else if (tx_start) begin
      starts++;
      dlog.push_back(tx_data);
      if (expq.size() == 0) begin
        check("start_without_handshake", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("tx_data", int'(tx_data), int'(e.d));
        check("grant_id", int'(grant_id), e.id);
        check("start_latency", cyc - e.cyc, 1);
      end
      cur = tx_data; have = 1;
    end else if (!idle && have) begin
      check("tx_data_stable", int'(tx_data), int'(cur));
    end
  end

  task automatic drain(input string name, input int maxc);
    int k = 0;
    while (!(all_empty() && expq.size() == 0 && idle && !tx_busy) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, int'(k >= maxc), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input string name, input int n, input int maxc);
    int k = 0;
    while (glog.size() < n && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check({name, "_grant_timeout"}, int'(k >= maxc), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int s0, nz, k;
    int exp37 [4];

    repeat (3) @(posedge clk);
    #3;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_idle", int'(idle), 1);
    @(posedge clk); #1 rst_n = 1;

    // All four requesters at once: order 0..3.
    glog.delete(); dlog.delete(); s0 = starts;
    for (int i = 0; i < N; i++) rq[i].push_back('{d: 8'(8'hA0 + i), l: 1'b1});
    drain("all4", 2000);
    check("all4_count", starts - s0, 4);
    for (int i = 0; i < 4; i++) begin
      check("all4_grant", glog[i], i);
      check("all4_data", int'(dlog[i]), 8'hA0 + i);
    end

    // Single requester back-to-back.
    glog.delete(); dlog.delete();
    rq[2].push_back('{d: 8'h55, l: 1'b1});
    rq[2].push_back('{d: 8'hAA, l: 1'b1});
    drain("single", 2000);
    check("single_count", glog.size(), 2);
    check("single_g0", glog[0], 2);
    check("single_g1", glog[1], 2);
    check("single_d1", int'(dlog[1]), 8'hAA);

    // External busy blocks arbitration.
    glog.delete();
    force_busy = 1;
    rq[0].push_back('{d: 8'h3C, l: 1'b1});
    nz = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != '0) nz++;
    end
    check("busy_blocks_ready", nz, 0);
    check("busy_blocks_grant", glog.size(), 0);
    @(posedge clk); #1 force_busy = 0;
    drain("busy", 2000);
    check("busy_then_grant_n", glog.size(), 1);
    check("busy_then_grant_id", glog[0], 0);

    // Packet from requester 1 competing with requester 0.
    do_reset();
    glog.delete();
    rq[1].push_back('{d: 8'h11, l: 1'b0});
    rq[1].push_back('{d: 8'h12, l: 1'b0});
    rq[1].push_back('{d: 8'h13, l: 1'b1});
    wait_grants("pkt", 1, 200);
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) rq[0].push_back('{d: 8'(8'h01 + j), l: 1'b1});
    drain("pkt", 3000);
`ifdef UART_ARB_LOCK_EN
    exp37 = '{1, 1, 1, 0};
`else
    exp37 = '{1, 0, 1, 0};
`endif
    check("pkt_count", glog.size(), 6);
    for (int i = 0; i < 4; i++) check("pkt_grant_order", glog[i], exp37[i]);

    // Reset in the middle of a transmission.
    glog.delete();
    rq[3].push_back('{d: 8'h33, l: 1'b1});
    wait_grants("rstmid", 1, 200);
    k = 0;
    while (!tx_busy && k < 50) begin @(negedge clk); k++; end
    check("rstmid_busy_timeout", int'(k >= 50), 0);
    repeat (3) @(negedge clk);
    rq[2].push_back('{d: 8'h42, l: 1'b1});
    rq[0].push_back('{d: 8'h40, l: 1'b1});
    #2 rst_n = 0;
    #1;
    check("rstmid_idle", int'(idle), 1);
    check("rstmid_tx_start", int'(tx_start), 0);
    check("rstmid_ready", int'(req_ready), 0);
    check("rstmid_tx_data", int'(tx_data), 0);
    glog.delete(); s0 = starts;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    drain("rstmid", 2000);
    check("rstmid_grants", glog.size(), 2);
    check("rstmid_first", glog[0], 0);
    check("rstmid_starts", starts - s0, 2);

    // Randomised packets with random valid gaps and busy lengths.
    rand_gap = 1; rand_busy = 1;
    for (int p = 0; p < 25; p++) begin
      int r, len;
      repeat ($urandom_range(6, 0)) @(posedge clk);
      #1;
      r   = int'($urandom_range(N-1, 0));
      len = int'($urandom_range(3, 1));
      for (int j = 0; j < len; j++) rq[r].push_back('{d: 8'($urandom), l: (j == len-1)});
    end
    drain("random", 20000);
    rand_gap = 0; rand_busy = 0; gap_en = '1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
